// File: rtl/cache_repl_pkg.sv
// Shared types and constants for the replacement-state scheduler.
package cache_repl_pkg;

    // SWEEP initialises every set; IDLE arbitrates touch requests.
    typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} repl_state_t;

    // Width of the optional grant/conflict counters.
    localparam int REPL_CNT_W = 32;

    // Way-index width for a given associativity.
    function automatic int lognumways(input int numways);
        return $clog2(numways);
    endfunction

endpackage

// File: rtl/cache_repl_sched_rr_arb.sv
// Two-input round-robin arbiter.
// req[0] is the hit-touch requester and req[1] is the fill-touch requester.
// ptr=0 favours req[1] on contention; ptr=1 favours req[0].
// The pointer flips only when both requests are present and en is high,
// so the loser of a contended grant is favoured next time.
module repl_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr
);

    // Zero-latency grant: a lone requester wins, contention resolved by ptr.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer flips to favour the loser after each contended grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (en && (req == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/cache_repl_sched.sv
// Replacement-state array scheduler: init sweep after reset/invalidate,
// then single-port write arbitration between hit-touch and fill-touch.
// Optional perf counters are built when REPL_SCHED_PERF_EN is defined.
// Handshake: a requester raises Req with Set/Way and holds them stable
// until the same-cycle Gnt; a Gnt means the write happens this cycle.
module cache_repl_sched
    import cache_repl_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int SETLEN   = 9,
    parameter int NUMLINES = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               InvalidateCache,
    input  logic               FlushStage,
    input  logic               HitReq,
    input  logic [SETLEN-1:0]  HitSet,
    input  logic [NUMWAYS-1:0] HitWay,
    input  logic               FillReq,
    input  logic [SETLEN-1:0]  FillSet,
    input  logic [NUMWAYS-1:0] FillWay,
    output logic               HitGnt,
    output logic               FillGnt,
    output logic               LRUWriteEn,
    output logic [SETLEN-1:0]  LRUSet,
    output logic [NUMWAYS-1:0] LRUWay,
    output logic               LRUInit,
    output logic               LFSRAdv,
    output logic               Busy,
    output logic               SweepDone,
    output logic               dbg_state,
    output logic               dbg_rr_ptr
`ifdef REPL_SCHED_PERF_EN
    ,
    output logic [REPL_CNT_W-1:0] HitGntCnt,
    output logic [REPL_CNT_W-1:0] FillGntCnt,
    output logic [REPL_CNT_W-1:0] ConflictCnt
`endif
);

    localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

    repl_state_t       state, state_nxt;
    logic [SETLEN-1:0] set_ctr, set_ctr_nxt;
    logic              sweep_done_nxt;
    logic              arb_en;
    logic [1:0]        arb_gnt;
    logic              sweep_start;

    repl_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({FillReq, HitReq}),
        .en    (arb_en),
        .gnt   (arb_gnt),
        .ptr   (dbg_rr_ptr)
    );

    // State, sweep counter and registered completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SWEEP;
            set_ctr   <= '0;
            SweepDone <= 1'b0;
        end else begin
            state     <= state_nxt;
            set_ctr   <= set_ctr_nxt;
            SweepDone <= sweep_done_nxt;
        end
    end

    // Next-state logic and output muxing for the sweep and arbitration phases.
    always_comb begin
        state_nxt      = state;
        set_ctr_nxt    = set_ctr;
        sweep_done_nxt = 1'b0;
        sweep_start    = 1'b0;
        arb_en         = 1'b0;
        LRUWriteEn     = 1'b0;
        LRUInit        = 1'b0;
        LRUSet         = '0;
        LRUWay         = '0;
        Busy           = 1'b0;
        case (state)
            SWEEP: begin
                LRUWriteEn = 1'b1;
                LRUInit    = 1'b1;
                LRUSet     = set_ctr;
                Busy       = 1'b1;
                if (InvalidateCache) begin
                    // Restart the sweep; the aborted one never reports done.
                    set_ctr_nxt = '0;
                    sweep_start = 1'b1;
                end else if (set_ctr == LAST_SET) begin
                    state_nxt      = IDLE;
                    set_ctr_nxt    = '0;
                    sweep_done_nxt = 1'b1;
                end else begin
                    set_ctr_nxt = set_ctr + SETLEN'(1);
                end
            end
            IDLE: begin
                if (InvalidateCache) begin
                    state_nxt   = SWEEP;
                    set_ctr_nxt = '0;
                    sweep_start = 1'b1;
                end else begin
                    arb_en = ~FlushStage;
                end
                if (arb_gnt[0]) begin
                    LRUWriteEn = 1'b1;
                    LRUSet     = HitSet;
                    LRUWay     = HitWay;
                end else if (arb_gnt[1]) begin
                    LRUWriteEn = 1'b1;
                    LRUSet     = FillSet;
                    LRUWay     = FillWay;
                end
            end
            default: begin
                state_nxt = SWEEP;
            end
        endcase
    end

    assign HitGnt    = arb_gnt[0];
    assign FillGnt   = arb_gnt[1];
    assign LFSRAdv   = arb_gnt[1];
    assign dbg_state = state;

`ifdef REPL_SCHED_PERF_EN
    // Saturating grant/conflict counters, cleared whenever a sweep starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HitGntCnt   <= '0;
            FillGntCnt  <= '0;
            ConflictCnt <= '0;
        end else if (sweep_start) begin
            HitGntCnt   <= '0;
            FillGntCnt  <= '0;
            ConflictCnt <= '0;
        end else begin
            if (arb_gnt[0] && !(&HitGntCnt))  HitGntCnt  <= HitGntCnt + REPL_CNT_W'(1);
            if (arb_gnt[1] && !(&FillGntCnt)) FillGntCnt <= FillGntCnt + REPL_CNT_W'(1);
            if ((state == IDLE) && HitReq && FillReq && !FlushStage && !(&ConflictCnt))
                ConflictCnt <= ConflictCnt + REPL_CNT_W'(1);
        end
    end
`endif

`ifndef SYNTHESIS
    a_hit_hold:    assert property (@(posedge clk) disable iff (!reset) HitReq && !HitGnt |=> HitReq);
    a_fill_hold:   assert property (@(posedge clk) disable iff (!reset) FillReq && !FillGnt |=> FillReq);
    a_hit_onehot:  assert property (@(posedge clk) disable iff (!reset) HitReq |-> $onehot(HitWay));
    a_fill_onehot: assert property (@(posedge clk) disable iff (!reset) FillReq |-> $onehot(FillWay));
`endif

endmodule

// File: tb/tb_cache_repl_sched.sv
// Directed bench for cache_repl_sched (NUMWAYS=4, SETLEN=9, NUMLINES=128).
// The driver pushes the expected output vector of every cycle it drives;
// a negedge monitor pops and compares against the live outputs.
module tb_cache_repl_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       InvalidateCache = 1'b0;
    logic       FlushStage = 1'b0;
    logic       HitReq = 1'b0;
    logic [8:0] HitSet = '0;
    logic [3:0] HitWay = '0;
    logic       FillReq = 1'b0;
    logic [8:0] FillSet = '0;
    logic [3:0] FillWay = '0;
    logic       HitGnt, FillGnt, LRUWriteEn, LRUInit, LFSRAdv, Busy, SweepDone;
    logic [8:0] LRUSet;
    logic [3:0] LRUWay;
    logic       dbg_state, dbg_rr_ptr;
`ifdef REPL_SCHED_PERF_EN
    logic [31:0] HitGntCnt, FillGntCnt, ConflictCnt;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [19:0] exp_q[$];
    string       name_q[$];

    cache_repl_sched #(.NUMWAYS(4), .SETLEN(9), .NUMLINES(128)) dut (
        .clk(clk), .reset(reset), .InvalidateCache(InvalidateCache), .FlushStage(FlushStage),
        .HitReq(HitReq), .HitSet(HitSet), .HitWay(HitWay),
        .FillReq(FillReq), .FillSet(FillSet), .FillWay(FillWay),
        .HitGnt(HitGnt), .FillGnt(FillGnt), .LRUWriteEn(LRUWriteEn), .LRUSet(LRUSet),
        .LRUWay(LRUWay), .LRUInit(LRUInit), .LFSRAdv(LFSRAdv), .Busy(Busy),
        .SweepDone(SweepDone), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
`ifdef REPL_SCHED_PERF_EN
        , .HitGntCnt(HitGntCnt), .FillGntCnt(FillGntCnt), .ConflictCnt(ConflictCnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Expected vector: {HitGnt,FillGnt,WriteEn,Init,LFSRAdv,Busy,SweepDone,Set[8:0],Way[3:0]}
    function automatic logic [19:0] mk(input logic hg, input logic fg, input logic we,
                                       input logic init, input logic adv, input logic busy,
                                       input logic done, input logic [8:0] set, input logic [3:0] way);
        return {hg, fg, we, init, adv, busy, done, set, way};
    endfunction

    function automatic logic [19:0] sweep_vec(input int s);
        logic [8:0] s9;
        s9 = s[8:0];
        return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s9, 4'b0000);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [19:0] act, exp_v;
        string nm;
        if (exp_q.size() > 0) begin
            act   = {HitGnt, FillGnt, LRUWriteEn, LRUInit, LFSRAdv, Busy, SweepDone, LRUSet, LRUWay};
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            vectors++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got hg/fg/we/init/adv/busy/done=%b set=%0d way=%b, expected %b set=%0d way=%b",
                         nm, act[19:13], act[12:4], act[3:0], exp_v[19:13], exp_v[12:4], exp_v[3:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic step(input logic inv, input logic flush,
                        input logic hreq, input logic [8:0] hset, input logic [3:0] hway,
                        input logic freq, input logic [8:0] fset, input logic [3:0] fway,
                        input logic [19:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        InvalidateCache = inv;
        FlushStage      = flush;
        HitReq  = hreq;  HitSet  = hset;  HitWay  = hway;
        FillReq = freq;  FillSet = fset;  FillWay = fway;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    // Sweep cycles from..to with an optional fill request held throughout.
    task automatic sweep_run(input int from, input int to, input logic freq,
                             input logic [8:0] fset, input logic [3:0] fway);
        for (int s = from; s <= to; s++)
            step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, freq, fset, fway, sweep_vec(s), "sweep");
    endtask

    task automatic check_cnt(input logic [31:0] act, input logic [31:0] exp_v, input string nm);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    localparam logic [19:0] NONE = 20'd0;

    // Stimulus
    initial begin
        // Reset held: sweep state, set 0 presented.
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0, sweep_vec(0), "reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back(sweep_vec(0));
        name_q.push_back("sweep0");
        sweep_run(1, 127, 1'b0, 9'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0,
             mk(0, 0, 0, 0, 0, 0, 1, 9'd0, 4'd0), "sweep_done");
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0, NONE, "idle");

        // Single hit touch, zero latency.
        step(1'b0, 1'b0, 1'b1, 9'd5, 4'b0010, 1'b0, 9'd0, 4'd0,
             mk(1, 0, 1, 0, 0, 0, 0, 9'd5, 4'b0010), "hit_single");

        // Contention for 4 cycles: Fill, Hit, Fill, Hit.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                step(1'b0, 1'b0, 1'b1, 9'd7, 4'b0001, 1'b1, 9'd9, 4'b1000,
                     mk(0, 1, 1, 0, 1, 0, 0, 9'd9, 4'b1000), "rr_fill");
            else
                step(1'b0, 1'b0, 1'b1, 9'd7, 4'b0001, 1'b1, 9'd9, 4'b1000,
                     mk(1, 0, 1, 0, 0, 0, 0, 9'd7, 4'b0001), "rr_hit");
        end

        // Flush blocks grants and leaves the pointer favouring fill.
        step(1'b0, 1'b1, 1'b1, 9'd11, 4'b0100, 1'b1, 9'd12, 4'b0010, NONE, "flush");
        step(1'b0, 1'b0, 1'b1, 9'd11, 4'b0100, 1'b1, 9'd12, 4'b0010,
             mk(0, 1, 1, 0, 1, 0, 0, 9'd12, 4'b0010), "after_flush_fill");
        step(1'b0, 1'b0, 1'b1, 9'd11, 4'b0100, 1'b0, 9'd0, 4'd0,
             mk(1, 0, 1, 0, 0, 0, 0, 9'd11, 4'b0100), "after_flush_hit");

        // Invalidate with a pending fill: no grant, sweep, then fill granted.
        step(1'b1, 1'b0, 1'b0, 9'd0, 4'd0, 1'b1, 9'd3, 4'b0100, NONE, "inv_idle_fill");
`ifdef REPL_SCHED_PERF_EN
        check_cnt(ConflictCnt, 32'd5, "conflict_cnt");
        check_cnt(HitGntCnt, 32'd4, "hit_cnt");
        check_cnt(FillGntCnt, 32'd3, "fill_cnt");
`endif
        sweep_run(0, 127, 1'b1, 9'd3, 4'b0100);
`ifdef REPL_SCHED_PERF_EN
        check_cnt(ConflictCnt, 32'd0, "conflict_cnt_clr");
        check_cnt(FillGntCnt, 32'd0, "fill_cnt_clr");
`endif
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b1, 9'd3, 4'b0100,
             mk(0, 1, 1, 0, 1, 0, 1, 9'd3, 4'b0100), "fill_after_sweep");

        // Invalidate aborted mid-sweep at set 60: restart, single done pulse.
        step(1'b1, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0, NONE, "inv_idle");
        sweep_run(0, 59, 1'b0, 9'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0, sweep_vec(60), "inv_at_60");
        sweep_run(0, 127, 1'b0, 9'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0,
             mk(0, 0, 0, 0, 0, 0, 1, 9'd0, 4'd0), "restart_done");
        step(1'b0, 1'b0, 1'b0, 9'd0, 4'd0, 1'b0, 9'd0, 4'd0, NONE, "idle_end");

        // Drain and report.
        @(posedge clk);
        @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
